sync_fifo_reader: RTL and testbench

- Drains the read side of sync_fifo and presents the data as a valid/ready stream to downstream logic.
- Handles the FIFO's registered read, where dout is valid one cycle after read_en with empty low.
- Uses a small 3-entry prefetch buffer so throughput is one word per cycle.
- No combinational path runs from m_ready to fifo_read_en.
- Keeps a running count of completed transfers for debug and perf.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/sync_fifo_reader_buf.sv | 61 ++++++
 rtl/sync_fifo_reader.sv | 61 ++++++
 tb/tb_sync_fifo_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo read-side logic.
// The reader buffer is a 3-entry circular store addressed by mod-3 pointers.
package fifo_pkg;

  localparam int READER_BUF_DEPTH = 3;
  localparam int READER_PTR_WIDTH = 2;
  localparam int FIFO_DATA_WIDTH  = 32;

  // Mod-3 pointer advance: 0 -> 1 -> 2 -> 0.
  function automatic logic [READER_PTR_WIDTH-1:0] ptr_inc(input logic [READER_PTR_WIDTH-1:0] p);
    return (p == READER_PTR_WIDTH'(READER_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo_reader_buf.sv
// Three-entry circular register buffer with push at the tail and pop at the head.
// Simultaneous push and pop keeps occupancy unchanged and preserves order.
module sync_fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       head_data,
  output logic [READER_PTR_WIDTH-1:0] occupancy
);

  logic [DATA_WIDTH-1:0]       mem_reg [READER_BUF_DEPTH];
  logic [READER_PTR_WIDTH-1:0] head_ptr_reg;
  logic [READER_PTR_WIDTH-1:0] tail_ptr_reg;
  logic [READER_PTR_WIDTH-1:0] occ_reg;
  logic [READER_PTR_WIDTH-1:0] occ_next;
  logic                        pop_ok;
  logic                        push_ok;

  // Guards keep the buffer self-consistent even if a caller misbehaves.
  assign pop_ok  = pop && (occ_reg != '0);
  assign push_ok = push && ((occ_reg != READER_PTR_WIDTH'(READER_BUF_DEPTH)) || pop_ok);

  always_comb begin
    occ_next = occ_reg;
    case ({push_ok, pop_ok})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READER_BUF_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      occ_reg      <= '0;
    end else begin
      if (push_ok) begin
        mem_reg[tail_ptr_reg] <= push_data;
        tail_ptr_reg          <= ptr_inc(tail_ptr_reg);
      end
      if (pop_ok) begin
        head_ptr_reg <= ptr_inc(head_ptr_reg);
      end
      occ_reg <= occ_next;
    end
  end

  assign head_data = mem_reg[head_ptr_reg];
  assign occupancy = occ_reg;

endmodule

// File: rtl/sync_fifo_reader.sv
// Drains a registered-read sync_fifo into a valid/ready stream at one word per cycle.
// Reads are issued from registered state only, so m_ready never reaches fifo_read_en.
module sync_fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_read_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  logic                        inflight_reg;
  logic [COUNT_WIDTH-1:0]      xfer_count_reg;
  logic [READER_PTR_WIDTH-1:0] occupancy;
  logic [READER_PTR_WIDTH:0]   committed;
  logic                        pop;

  // Words already buffered plus the one whose FIFO read is still in flight.
  assign committed    = {1'b0, occupancy} + {{READER_PTR_WIDTH{1'b0}}, inflight_reg};
  assign fifo_read_en = enable & ~fifo_empty & ~reset
                      & (committed < (READER_PTR_WIDTH + 1)'(READER_BUF_DEPTH));

  assign m_valid = (occupancy != '0);
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_reg   <= 1'b0;
      xfer_count_reg <= '0;
    end else begin
      inflight_reg <= fifo_read_en;
      if (pop) begin
        xfer_count_reg <= xfer_count_reg + 1'b1;
      end
    end
  end

  sync_fifo_reader_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_reg),
    .push_data (fifo_dout),
    .pop       (pop),
    .head_data (m_data),
    .occupancy (occupancy)
  );

  assign xfer_count = xfer_count_reg;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: a queue-based sync_fifo, a transaction-level model
// of the reader, per-cycle output comparison and directed literal checks.
module tb_sync_fifo_reader;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] xfer_count;

  always #5 clock = ~clock;

  sync_fifo_reader #(
    .DATA_WIDTH  (DW),
    .COUNT_WIDTH (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_read_en (fifo_read_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .xfer_count   (xfer_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment FIFO and model state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] model_fifo[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mpend = '0;
  bit            minf = 1'b0;
  logic [CW-1:0] mcount = '0;
  logic [DW-1:0] beat_log[$];
  int            beat_cyc[$];
  logic [DW-1:0] src_log[$];
  int            cyc = 0;
  int            rd_pulses = 0;
  logic [DW-1:0] pop_w;
  bit            mdl_ren;
  bit            exp_ren;

  always @(posedge clock) begin
    cyc++;
    if (fifo_read_en) rd_pulses++;
    if (fifo_read_en && fifo_q.size() != 0) begin
      pop_w = fifo_q.pop_front();
      fifo_dout <= pop_w;
    end
    fifo_empty <= (fifo_q.size() == 0);
    if (m_valid && m_ready && !reset) begin
      beat_log.push_back(m_data);
      beat_cyc.push_back(cyc);
    end
    if (!reset) begin
      mdl_ren = enable && (model_fifo.size() != 0) && (mq.size() + int'(minf) < 3);
      if (mq.size() != 0 && m_ready) begin
        mq.delete(0);
        mcount = mcount + 1'b1;
      end
      if (minf) mq.push_back(mpend);
      if (mdl_ren) mpend = model_fifo.pop_front();
      minf = mdl_ren;
    end
  end

  always @(negedge clock) begin
    exp_ren = !reset && enable && (model_fifo.size() != 0) && (mq.size() + int'(minf) < 3);
    check("read_en", {31'b0, fifo_read_en}, {31'b0, exp_ren});
    check("m_valid", {31'b0, m_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) check("m_data", m_data, mq[0]);
    check("xfer_count", {24'b0, xfer_count}, {24'b0, mcount});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    model_fifo.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mq.delete();
    minf   = 1'b0;
    mpend  = '0;
    mcount = '0;
    #1;
    check("rst_read_en", {31'b0, fifo_read_en}, 32'd0);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_xfer_count", {24'b0, xfer_count}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_beats(input string name, input int n, input int bound);
    int k = 0;
    while (beat_log.size() < n && k < bound) begin
      tick();
      k++;
    end
    check(name, beat_log.size(), n);
  endtask

  initial begin
    int k;
    logic [31:0] base;
    tick();
    do_reset();

    // Preloaded burst with a ready consumer
    enable = 1'b1; m_ready = 1'b1; beat_log.delete(); beat_cyc.delete();
    for (int i = 0; i < 8; i++) push_word(32'hA0 + i);
    #1;
    check("t1_first_read_en", {31'b0, fifo_read_en}, 32'd1);
    tick();
    check("t1_valid_lat1", {31'b0, m_valid}, 32'd0);
    tick();
    check("t1_valid_lat2", {31'b0, m_valid}, 32'd1);
    check("t1_first_data", m_data, 32'hA0);
    wait_beats("t1_beats", 8, 20);
    for (int i = 0; i < beat_log.size(); i++) begin
      check("t1_data", beat_log[i], 32'hA0 + i);
      check("t1_gap", beat_cyc[i] - beat_cyc[0], i);
    end
    check("t1_count", {24'b0, xfer_count}, 32'd8);
    check("t1_drained", {31'b0, m_valid}, 32'd0);

    // Full backpressure, then release
    do_reset();
    m_ready = 1'b0; rd_pulses = 0; beat_log.delete(); beat_cyc.delete();
    for (int i = 0; i < 8; i++) push_word(32'hA0 + i);
    repeat (10) tick();
    check("t2_pulses", rd_pulses, 32'd3);
    check("t2_read_en_held", {31'b0, fifo_read_en}, 32'd0);
    check("t2_head_held", m_data, 32'hA0);
    m_ready = 1'b1;
    wait_beats("t2_beats", 8, 30);
    for (int i = 0; i < beat_log.size(); i++) begin
      check("t2_data", beat_log[i], 32'hA0 + i);
      check("t2_gap", beat_cyc[i] - beat_cyc[0], i);
    end

    // Toggling ready over a 16-word stream
    do_reset();
    beat_log.delete();
    for (int i = 0; i < 16; i++) push_word(i);
    k = 0;
    while (beat_log.size() < 16 && k < 100) begin
      m_ready = ~m_ready;
      tick();
      k++;
    end
    check("t3_beats", beat_log.size(), 32'd16);
    for (int i = 0; i < beat_log.size(); i++) check("t3_data", beat_log[i], i);

    // Enable dropped after the second read
    do_reset();
    m_ready = 1'b1; rd_pulses = 0; beat_log.delete();
    for (int i = 0; i < 8; i++) push_word(32'h40 + i);
    tick();
    tick();
    enable = 1'b0;
    check("t4_pulses", rd_pulses, 32'd2);
    repeat (8) tick();
    check("t4_beats_held", beat_log.size(), 32'd2);
    check("t4_pulses_held", rd_pulses, 32'd2);
    enable = 1'b1;
    wait_beats("t4_beats", 8, 30);
    for (int i = 0; i < beat_log.size(); i++) check("t4_data", beat_log[i], 32'h40 + i);

    // Asynchronous reset with two buffered words and one in flight
    m_ready = 1'b0; rd_pulses = 0; beat_log.delete();
    for (int i = 0; i < 6; i++) push_word(32'h50 + i);
    repeat (3) tick();
    check("t5_pulses", rd_pulses, 32'd3);
    check("t5_valid_before", {31'b0, m_valid}, 32'd1);
    #2;
    do_reset();
    beat_log.delete();
    m_ready = 1'b1;
    wait_beats("t5_beats", 3, 20);
    for (int i = 0; i < beat_log.size(); i++) check("t5_data", beat_log[i], 32'h53 + i);

    // Counter wrap at all-ones
    do_reset();
    for (int i = 0; i < 258; i++) push_word(i);
    k = 0;
    while (xfer_count != 8'hFF && k < 400) begin
      tick();
      k++;
    end
    check("t6_reach_ff", {24'b0, xfer_count}, 32'hFF);
    check("t6_valid", {31'b0, m_valid}, 32'd1);
    tick();
    check("t6_wrap", {24'b0, xfer_count}, 32'd0);
    k = 0;
    while ((fifo_q.size() != 0 || m_valid) && k < 50) begin
      tick();
      k++;
    end

    // Randomized traffic
    do_reset();
    beat_log.delete(); src_log.delete();
    for (int c = 0; c < 600; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) begin
        base = $urandom;
        push_word(base);
        src_log.push_back(base);
      end
      tick();
    end
    enable = 1'b1; m_ready = 1'b1;
    k = 0;
    while ((model_fifo.size() != 0 || mq.size() != 0 || minf) && k < 100) begin
      tick();
      k++;
    end
    check("t7_beats", beat_log.size(), src_log.size());
    for (int i = 0; i < beat_log.size() && i < src_log.size(); i++) check("t7_data", beat_log[i], src_log[i]);
    check("t7_count", {24'b0, xfer_count}, beat_log.size() % 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
